// File: rtl/dvfs_step_sequencer.sv
// Orders one voltage/frequency operating-point change for a power domain:
// voltage goes up before frequency rises, frequency comes down before voltage drops.
module dvfs_step_sequencer #(
    parameter int unsigned VW            = 2,
    parameter int unsigned FW            = 3,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned ACK_TIMEOUT   = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [VW-1:0] tgt_v,
    input  logic [FW-1:0] tgt_f,
    output logic [VW-1:0] vreg_set,
    output logic          vreg_req,
    input  logic          vreg_ack,
    output logic [FW-1:0] fsel,
    output logic [VW-1:0] cur_v,
    output logic          done,
    output logic          err
);

    localparam logic [2:0] StIdle       = 3'd0;
    localparam logic [2:0] StFApplyPre  = 3'd1;
    localparam logic [2:0] StVReq       = 3'd2;
    localparam logic [2:0] StVSettle    = 3'd3;
    localparam logic [2:0] StFApplyPost = 3'd4;
    localparam logic [2:0] StDone       = 3'd5;

    // One counter serves both the ack-wait and the settle interval.
    localparam int unsigned CntMax = (ACK_TIMEOUT > SETTLE_CYCLES) ? ACK_TIMEOUT : SETTLE_CYCLES;
    localparam int unsigned CW     = $clog2(CntMax + 1);

    localparam logic [CW-1:0] AckLast    = CW'(ACK_TIMEOUT - 1);
    localparam logic [CW-1:0] SettleLast = CW'(SETTLE_CYCLES - 1);

    logic [2:0]    state_q, state_d;
    logic [VW-1:0] tgt_v_q, tgt_v_d;
    logic [FW-1:0] tgt_f_q, tgt_f_d;
    logic [VW-1:0] cur_v_q, cur_v_d;
    logic [FW-1:0] fsel_q, fsel_d;
    logic          err_q, err_d;
    logic          up_q, up_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        tgt_v_d = tgt_v_q;
        tgt_f_d = tgt_f_q;
        cur_v_d = cur_v_q;
        fsel_d  = fsel_q;
        err_d   = err_q;
        up_d    = up_q;
        cnt_d   = cnt_q;

        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    tgt_v_d = tgt_v;
                    tgt_f_d = tgt_f;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    if (tgt_v > cur_v_q) begin
                        up_d    = 1'b1;
                        state_d = StVReq;
                    end else if (tgt_v < cur_v_q) begin
                        up_d    = 1'b0;
                        state_d = StFApplyPre;
                    end else begin
                        up_d    = 1'b0;
                        state_d = StFApplyPost;
                    end
                end
            end
            StFApplyPre: begin
                fsel_d  = tgt_f_q;
                cnt_d   = '0;
                state_d = StVReq;
            end
            StVReq: begin
                if (vreg_ack) begin
                    cur_v_d = tgt_v_q;
                    cnt_d   = SettleLast;
                    state_d = StVSettle;
                end else if (cnt_q == AckLast) begin
                    // Timeout: a frequency already lowered on the down path stays lowered.
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StVSettle: begin
                if (cnt_q == '0) begin
                    state_d = up_q ? StFApplyPost : StDone;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StFApplyPost: begin
                fsel_d  = tgt_f_q;
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            tgt_v_q <= '0;
            tgt_f_q <= '0;
            cur_v_q <= '0;
            fsel_q  <= '0;
            err_q   <= 1'b0;
            up_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            tgt_v_q <= tgt_v_d;
            tgt_f_q <= tgt_f_d;
            cur_v_q <= cur_v_d;
            fsel_q  <= fsel_d;
            err_q   <= err_d;
            up_q    <= up_d;
            cnt_q   <= cnt_d;
        end
    end

    assign req_ready = (state_q == StIdle);
    assign vreg_req  = (state_q == StVReq);
    assign vreg_set  = (state_q == StVReq) ? tgt_v_q : cur_v_q;
    assign fsel      = fsel_q;
    assign cur_v     = cur_v_q;
    assign done      = (state_q == StDone);
    assign err       = err_q;

endmodule

// File: tb/tb_dvfs_step_sequencer.sv
// Directed bench for dvfs_step_sequencer: up, down, equal, timeout, busy-ignore and reset cases.
module tb_dvfs_step_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] tgt_v;
    logic [2:0] tgt_f;
    logic [1:0] vreg_set;
    logic       vreg_req;
    logic       vreg_ack;
    logic [2:0] fsel;
    logic [1:0] cur_v;
    logic       done;
    logic       err;

    int n_cmp = 0;
    int n_bad = 0;

    dvfs_step_sequencer #(
        .VW           (2),
        .FW           (3),
        .SETTLE_CYCLES(4),
        .ACK_TIMEOUT  (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .tgt_v    (tgt_v),
        .tgt_f    (tgt_f),
        .vreg_set (vreg_set),
        .vreg_req (vreg_req),
        .vreg_ack (vreg_ack),
        .fsel     (fsel),
        .cur_v    (cur_v),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs until idle, acking the regulator as soon as it asks; bounded.
    task automatic wait_idle(input string tag);
        int n = 0;
        while (!req_ready && n < 40) begin
            vreg_ack = vreg_req;
            tick();
            n++;
        end
        vreg_ack = 1'b0;
        check_value(tag, 8'(req_ready), 8'd1);
    endtask

    task automatic do_req(input logic [1:0] v, input logic [2:0] f, input string tag);
        req_valid = 1'b1;
        tgt_v     = v;
        tgt_f     = f;
        tick();
        req_valid = 1'b0;
        wait_idle(tag);
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        tgt_v     = '0;
        tgt_f     = '0;
        vreg_ack  = 1'b0;
        tick();
        tick();
        #2 reset = 1'b0;
        tick();

        // Reset state
        check_value("rst_ready", 8'(req_ready), 8'd1);
        check_value("rst_cur_v", 8'(cur_v), 8'd0);
        check_value("rst_fsel", 8'(fsel), 8'd0);
        check_value("rst_vreq", 8'(vreg_req), 8'd0);
        check_value("rst_vset", 8'(vreg_set), 8'd0);
        check_value("rst_err", 8'(err), 8'd0);
        check_value("rst_done", 8'(done), 8'd0);

        // Up step 0 -> v=2, f=3, ack two cycles after vreg_req rises
        req_valid = 1'b1;
        tgt_v     = 2'd2;
        tgt_f     = 3'd3;
        tick();
        req_valid = 1'b0;
        check_value("up_vreq", 8'(vreg_req), 8'd1);
        check_value("up_vset", 8'(vreg_set), 8'd2);
        check_value("up_busy", 8'(req_ready), 8'd0);
        check_value("up_cur_v_pre", 8'(cur_v), 8'd0);
        tick();
        check_value("up_vreq_wait", 8'(vreg_req), 8'd1);
        vreg_ack = 1'b1;
        tick();
        vreg_ack = 1'b0;
        check_value("up_cur_v", 8'(cur_v), 8'd2);
        check_value("up_vreq_drop", 8'(vreg_req), 8'd0);
        check_value("up_fsel_hold", 8'(fsel), 8'd0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_value("up_fsel_settle", 8'(fsel), 8'd0);
            check_value("up_done_early", 8'(done), 8'd0);
        end
        tick();
        check_value("up_fsel", 8'(fsel), 8'd3);
        check_value("up_done", 8'(done), 8'd1);
        tick();
        check_value("up_done_pulse", 8'(done), 8'd0);
        check_value("up_ready", 8'(req_ready), 8'd1);

        // Move to v=3, f=7, then down step to v=1, f=0
        do_req(2'd3, 3'd7, "setup37_idle");
        check_value("setup37_v", 8'(cur_v), 8'd3);
        check_value("setup37_f", 8'(fsel), 8'd7);
        req_valid = 1'b1;
        tgt_v     = 2'd1;
        tgt_f     = 3'd0;
        tick();
        req_valid = 1'b0;
        check_value("dn_vreq_e0", 8'(vreg_req), 8'd0);
        check_value("dn_fsel_e0", 8'(fsel), 8'd7);
        tick();
        check_value("dn_fsel_e1", 8'(fsel), 8'd0);
        check_value("dn_vreq_e1", 8'(vreg_req), 8'd1);
        check_value("dn_vset", 8'(vreg_set), 8'd1);
        check_value("dn_cur_v_pre", 8'(cur_v), 8'd3);
        vreg_ack = 1'b1;
        tick();
        vreg_ack = 1'b0;
        check_value("dn_cur_v", 8'(cur_v), 8'd1);
        check_value("dn_vreq_drop", 8'(vreg_req), 8'd0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check_value("dn_done_early", 8'(done), 8'd0);
        end
        tick();
        check_value("dn_done", 8'(done), 8'd1);
        tick();
        check_value("dn_ready", 8'(req_ready), 8'd1);

        // Equal voltage v=1, f=5
        req_valid = 1'b1;
        tgt_v     = 2'd1;
        tgt_f     = 3'd5;
        tick();
        req_valid = 1'b0;
        check_value("eq_vreq_e0", 8'(vreg_req), 8'd0);
        check_value("eq_fsel_e0", 8'(fsel), 8'd0);
        tick();
        check_value("eq_fsel_e1", 8'(fsel), 8'd5);
        check_value("eq_done", 8'(done), 8'd1);
        check_value("eq_vreq_e1", 8'(vreg_req), 8'd0);
        tick();
        check_value("eq_done_pulse", 8'(done), 8'd0);
        check_value("eq_ready", 8'(req_ready), 8'd1);
        check_value("eq_cur_v", 8'(cur_v), 8'd1);

        // Timeout: go to v=0, then ask for v=3 with ack held low
        do_req(2'd0, 3'd5, "setup05_idle");
        check_value("setup05_v", 8'(cur_v), 8'd0);
        req_valid = 1'b1;
        tgt_v     = 2'd3;
        tgt_f     = 3'd2;
        tick();
        req_valid = 1'b0;
        for (int i = 1; i <= 15; i++) tick();
        check_value("to_vreq_e15", 8'(vreg_req), 8'd1);
        check_value("to_err_e15", 8'(err), 8'd0);
        tick();
        check_value("to_err", 8'(err), 8'd1);
        check_value("to_vreq", 8'(vreg_req), 8'd0);
        check_value("to_cur_v", 8'(cur_v), 8'd0);
        check_value("to_fsel", 8'(fsel), 8'd5);
        check_value("to_ready", 8'(req_ready), 8'd1);
        tick();
        check_value("to_err_sticky", 8'(err), 8'd1);
        req_valid = 1'b1;
        tgt_v     = 2'd0;
        tgt_f     = 3'd1;
        tick();
        req_valid = 1'b0;
        check_value("to_err_clear", 8'(err), 8'd0);
        wait_idle("clr_idle");

        // Ack on exactly the 16th edge succeeds
        req_valid = 1'b1;
        tgt_v     = 2'd3;
        tgt_f     = 3'd4;
        tick();
        req_valid = 1'b0;
        for (int i = 1; i <= 15; i++) tick();
        vreg_ack = 1'b1;
        tick();
        vreg_ack = 1'b0;
        check_value("ack16_cur_v", 8'(cur_v), 8'd3);
        check_value("ack16_err", 8'(err), 8'd0);
        check_value("ack16_vreq", 8'(vreg_req), 8'd0);
        wait_idle("ack16_idle");
        check_value("ack16_fsel", 8'(fsel), 8'd4);

        // Busy ignore: request 0/0 during settle of a 3->2 down step
        req_valid = 1'b1;
        tgt_v     = 2'd2;
        tgt_f     = 3'd6;
        tick();
        req_valid = 1'b0;
        tick();
        vreg_ack = 1'b1;
        tick();
        vreg_ack = 1'b0;
        req_valid = 1'b1;
        tgt_v     = 2'd0;
        tgt_f     = 3'd0;
        tick();
        req_valid = 1'b0;
        wait_idle("busy_idle");
        tick();
        tick();
        check_value("busy_cur_v", 8'(cur_v), 8'd2);
        check_value("busy_fsel", 8'(fsel), 8'd6);
        check_value("busy_vreq", 8'(vreg_req), 8'd0);
        check_value("busy_ready", 8'(req_ready), 8'd1);

        // Reset during V_REQ drops vreg_req without a clock edge
        req_valid = 1'b1;
        tgt_v     = 2'd3;
        tgt_f     = 3'd1;
        tick();
        req_valid = 1'b0;
        check_value("mid_vreq", 8'(vreg_req), 8'd1);
        #2 reset = 1'b1;
        #1;
        check_value("mid_rst_vreq", 8'(vreg_req), 8'd0);
        check_value("mid_rst_cur_v", 8'(cur_v), 8'd0);
        check_value("mid_rst_fsel", 8'(fsel), 8'd0);
        check_value("mid_rst_ready", 8'(req_ready), 8'd1);
        tick();
        reset = 1'b0;
        tick();
        check_value("post_rst_vreq", 8'(vreg_req), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
